sine_pwm_dac: RTL and testbench
===============================

// Module: sine_pwm_dac
// PURPOSE
//   Downstream output stage of the pure sine generator: accepts unsigned offset-binary
//   sine samples over a valid/ready handshake and converts each into one PWM frame on a
//   single pin (external RC filter recovers the sine). A one-entry holding buffer
//   decouples the sample producer from the frame timing. Missed frames raise a sticky
//   underrun flag.
// PARAMETERS
//   DATA_W  8  sample width; PWM frame = 2**DATA_W ticks
//   DIV_W   4  width of tick prescale divider input
// PORTS
//   clk          in   1       system clock
//   rst_n        in   1       synchronous, active-low reset
//   en           in   1       run request
//   div          in   DIV_W   tick every div+1 clocks; sampled at each prescale wrap
//   s_valid      in   1       sample valid
//   s_ready      out  1       buffer can accept (= ~hold_full, combinational)
//   s_data       in   DATA_W  sample, unsigned offset binary (0x80 = midscale)
//   clr_underrun in   1       clears underrun
//   pwm_out      out  1       PWM output, registered
//   frame_start  out  1       1-clk pulse on the first clock of each frame
//   underrun     out  1       sticky: frame boundary reached with empty buffer
//   busy         out  1       high in RUN or DRAIN
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state=IDLE, pre=0, cnt=0, duty=0, hold_full=0,
//     pwm_out=0, frame_start=0, underrun=0; s_ready=1 the cycle after.
//   Accept: s_valid & s_ready -> hold<=s_data, hold_full<=1 (allowed in any state).
//   Prescaler: pre counts 0..div; tick when pre==div (pre wraps to 0). div=0 -> tick each clk.
//   Frame counter cnt increments on tick; boundary = tick while cnt==2**DATA_W-1 (cnt->0).
//   States:
//     IDLE : pre, cnt held at 0, pwm_out=0. en=1 -> RUN: cnt=0, pre=0,
//            duty<=hold (hold_full<=0) if full else duty<=0 (no underrun), frame_start=1.
//     RUN  : at boundary: hold_full -> duty<=hold, hold_full<=0; empty -> duty kept,
//            underrun<=1. frame_start=1 on clock after boundary. en=0 -> DRAIN.
//     DRAIN: continues current frame, loads/underrun as RUN; at boundary -> IDLE
//            (no load, no underrun, pwm_out=0). en=1 in DRAIN -> RUN, frame undisturbed.
//   pwm_out <= (state!=IDLE) & (cnt < duty): high exactly duty*(div+1) clks per frame;
//     duty=0 -> constant 0; duty=2**DATA_W-1 -> low for one tick per frame.
//   Boundary uses pre-edge state: sample accepted on boundary clock goes to hold, not
//     duty; underrun still set if hold was empty before that edge.
//   underrun: set and clr_underrun same clock -> set wins. Clear only via clr or reset.
//   busy = (state==RUN)|(state==DRAIN). No combinational path s_valid->s_ready.
//   Reset mid-frame: all state per reset list, held sample discarded.
// TESTING
//   1 Reset: rst_n=0 2 clks -> pwm_out=0, underrun=0, busy=0, s_ready=1, frame_start=0.
//   2 div=0, preload 0x40, en=1, feed 0x40 every frame -> 64 high clks per 256-clk frame,
//     frame_start every 256 clks, underrun=0.
//   3 Extremes div=0: 0x00 -> pwm_out never high; 0xFF -> 255 high / 1 low per frame.
//   4 div=3, sample 0x80 -> frame 1024 clks, 512 high; change div mid-frame applies at
//     next prescale wrap.
//   5 Underrun: stop feeding after frame 1 -> underrun=1 at boundary, duty repeats;
//     clr_underrun same clk as next underrun -> stays 1.
//   6 en=0 mid-frame -> DRAIN completes frame, then IDLE, busy=0; en re-raised in DRAIN
//     -> frame continues with no gap.

Source files
------------

// File: rtl/sine_pwm_dac.sv
// PWM output stage for the sine generator: one buffered offset-binary sample per PWM frame,
// with a programmable tick prescaler and a sticky underrun flag for missed frames.
module sine_pwm_dac #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              clr_underrun,
    output logic              pwm_out,
    output logic              frame_start,
    output logic              underrun,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] CNT_MAX = '1;

    state_t              state;
    logic [DIV_W-1:0]    pre;
    logic [DIV_W-1:0]    div_q;
    logic [DATA_W-1:0]   cnt;
    logic [DATA_W-1:0]   duty;
    logic [DATA_W-1:0]   hold;
    logic                hold_full;

    logic tick;
    logic boundary;
    logic last;
    logic accept;
    logic underrun_set;

    // div is latched only at a prescale wrap so a mid-frame change never truncates a tick.
    assign tick         = (state != IDLE) && (pre == div_q);
    assign boundary     = tick && (cnt == CNT_MAX);
    assign last         = (state == DRAIN) && !en && boundary;
    assign accept       = s_valid && !hold_full;
    assign underrun_set = boundary && !last && !hold_full;

    assign s_ready = ~hold_full;
    assign busy    = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pre         <= '0;
            div_q       <= '0;
            cnt         <= '0;
            duty        <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            // Accept and load are exclusive: accept needs an empty buffer, load a full one.
            if (accept) begin
                hold      <= s_data;
                hold_full <= 1'b1;
            end

            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    pre     <= '0;
                    cnt     <= '0;
                    div_q   <= div;
                    pwm_out <= 1'b0;
                    if (en) begin
                        state       <= RUN;
                        frame_start <= 1'b1;
                        if (hold_full) begin
                            duty      <= hold;
                            hold_full <= 1'b0;
                        end else begin
                            duty <= '0;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        pre   <= '0;
                        div_q <= div;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end

                    if (last) begin
                        state   <= IDLE;
                        pwm_out <= 1'b0;
                    end else begin
                        state   <= en ? RUN : DRAIN;
                        pwm_out <= (cnt < duty);
                        if (boundary) begin
                            frame_start <= 1'b1;
                            if (hold_full) begin
                                duty      <= hold;
                                hold_full <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Bench for sine_pwm_dac: stimulus pushes per-frame {length, high clocks} expectations,
// a monitor measures each frame between frame_start pulses (or drain end) and compares.
module tb_sine_pwm_dac;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] div;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       clr_underrun;
    logic       pwm_out;
    logic       frame_start;
    logic       underrun;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    // Expected frame record: [31:16] frame length in clocks, [15:0] high clocks.
    logic [31:0] exp_q[$];

    sine_pwm_dac #(.DATA_W(8), .DIV_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div          (div),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .clr_underrun (clr_underrun),
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_frame(input int len, input int high);
        exp_q.push_back({len[15:0], high[15:0]});
    endtask

    // All driving happens at negedge; the DUT samples at the following posedge.
    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!s_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 4000);
        check("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("drain_to_idle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: measures each frame window and pops the matching expectation.
    int  mon_len  = 0;
    int  mon_high = 0;
    bit  mon_open = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_open = 1'b0;
        end else begin
            if (mon_open && (frame_start || !busy)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("frame_len", mon_len, {16'd0, e[31:16]});
                    check("frame_high", mon_high, {16'd0, e[15:0]});
                end
                mon_open = 1'b0;
            end
            if (frame_start) begin
                mon_open = 1'b1;
                mon_len  = 0;
                mon_high = 0;
            end
            if (mon_open) begin
                mon_len++;
                if (pwm_out) mon_high++;
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        div          = 4'd0;
        s_valid      = 1'b0;
        s_data       = 8'h00;
        clr_underrun = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pwm_out", {31'd0, pwm_out}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_frame_start", {31'd0, frame_start}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // div=0: preload in IDLE, then a run of frames with varied duties
        send(8'h40);
        check("hold_full_blocks_ready", {31'd0, s_ready}, 32'd0);
        en = 1'b1;
        push_frame(256, 64);
        wait_fs();
        check("busy_in_run", {31'd0, busy}, 32'd1);
        send(8'h40); push_frame(256, 64);
        send(8'h00); push_frame(256, 0);
        send(8'hFF); push_frame(256, 255);
        send(8'h40); push_frame(256, 64);
        wait_fs();
        check("no_underrun_when_fed", {31'd0, underrun}, 32'd0);

        // Underrun: buffer left empty, duty repeats
        push_frame(256, 64);
        wait_fs();
        check("underrun_set", {31'd0, underrun}, 32'd1);
        repeat (4) @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("underrun_cleared", {31'd0, underrun}, 32'd0);
        push_frame(256, 64);
        repeat (250) @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("boundary_frame_start", {31'd0, frame_start}, 32'd1);
        check("underrun_set_beats_clr", {31'd0, underrun}, 32'd1);

        // Drain with en re-raised mid-frame: frame continues without a gap
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("busy_in_drain", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        en = 1'b1;
        push_frame(256, 64);
        wait_fs();
        repeat (20) @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_idle();
        @(negedge clk);
        check("idle_pwm_low", {31'd0, pwm_out}, 32'd0);
        check("drain_no_underrun", {31'd0, underrun}, 32'd0);
        check("idle_s_ready", {31'd0, s_ready}, 32'd1);

        // div=3 midscale frame, then div changed to 1 one clock into the next frame
        div = 4'd3;
        send(8'h80);
        en = 1'b1;
        push_frame(1024, 512);
        wait_fs();
        send(8'h80);
        // First tick keeps the old divider (4 clks), remaining 255 ticks take 2 clks.
        push_frame(514, 258);
        wait_fs();
        @(negedge clk);
        div = 4'd1;
        send(8'h80);
        push_frame(512, 256);
        wait_fs();
        en = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("all_frames_seen", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
